// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that shares one iterative 3-cycle divider among N_REQ requesters.
// Zero divisors are answered locally with a saturated quotient and never reach the divider.
module div_share_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_rsp_valid,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic                    o_rsp_dz,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_div_a,
  output logic [DATA_W-1:0]       o_div_b,
  output logic                    o_div_en,
  input  logic                    i_div_fin,
  input  logic [DATA_W-1:0]       i_div_result,
  output logic                    o_busy
);

  localparam int unsigned       WD_W    = 2;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(3);
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dz_q, dz_d;
  logic              wd_q, wd_d;
  logic [WD_W-1:0]   cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              div_en_q, div_en_d;
  logic              busy_q, busy_d;

  logic              found_c;
  logic              open_c;
  logic [ID_W-1:0]   cand_c;
  logic [ID_W-1:0]   win_c;
  logic [DATA_W-1:0] win_a_c;
  logic [DATA_W-1:0] win_b_c;
  logic [N_REQ-1:0]  req_ready_c;

  // Round-robin winner: first valid requester after the last one served.
  always_comb begin
    found_c = 1'b0;
    cand_c  = '0;
    win_c   = '0;
    win_a_c = '0;
    win_b_c = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      cand_c = ID_W'((32'(ptr_q) + n + 32'd1) % N_REQ);
      if (!found_c && i_req_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_c == ID_W'(k)) begin
        win_a_c = i_req_a[k*DATA_W +: DATA_W];
        win_b_c = i_req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath; a zero divisor spends one quiet RUN cycle with the divider idle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    dz_d        = dz_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    open_c      = 1'b0;
    req_ready_c = '0;

    unique case (state_q)
      IDLE: open_c = 1'b1;
      RUN: begin
        if (dz_q) begin
          state_d = RESP;
        end else if (i_div_fin) begin
          data_d  = i_div_result;
          state_d = RESP;
        end else if (cnt_q == WD_LAST) begin
          data_d  = '0;
          dz_d    = 1'b1;
          wd_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + WD_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
          wd_d    = 1'b0;
          open_c  = !wd_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (open_c && found_c) begin
      req_ready_c = N_REQ'(1) << win_c;
      ptr_d       = win_c;
      id_d        = win_c;
      a_d         = win_a_c;
      b_d         = win_b_c;
      cnt_d       = '0;
      wd_d        = 1'b0;
      state_d     = RUN;
      if (win_b_c == '0) begin
        dz_d   = 1'b1;
        data_d = win_a_c[DATA_W-1] ? SAT_NEG : SAT_POS;
      end else begin
        dz_d = 1'b0;
      end
    end

    rsp_valid_d = (state_d == RESP);
    div_en_d    = (state_d == RUN) && !dz_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      dz_q        <= 1'b0;
      wd_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      div_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      dz_q        <= dz_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      div_en_q    <= div_en_d;
      busy_q      <= busy_d;
    end
  end

  assign o_req_ready = req_ready_c;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_data  = data_q;
  assign o_rsp_dz    = dz_q;
  assign o_div_a     = a_q;
  assign o_div_b     = b_q;
  assign o_div_en    = div_en_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: stub 3-cycle divider, transaction-level model checked every cycle,
// and directed scenarios with literal expectations.
module tb_div_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_dz;
  logic        rsp_ready;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic        div_en;
  logic        div_fin;
  logic [15:0] div_result;
  logic        busy;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt = 0;

  typedef struct {int cyc; int id; logic [3:0] oh;} grant_t;
  typedef struct {int cyc; int id; logic [15:0] data; logic dz;} rsp_t;
  grant_t gq[$];
  rsp_t   rq[$];

  div_share_arbiter #(.N_REQ(4), .ID_W(2), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_dz(rsp_dz),
    .i_rsp_ready(rsp_ready),
    .o_div_a(div_a), .o_div_b(div_b), .o_div_en(div_en),
    .i_div_fin(div_fin), .i_div_result(div_result), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S1.14 / 2.14 quotient in S1.14, saturated
  function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
    int sa, q;
    sa = int'($signed(a));
    if (b == 16'h0) return 16'h0;
    q = (sa * 16384) / int'({16'h0, b});
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  // Divider stub: fin on third enabled cycle; frozen entirely when stall is set
  logic [1:0] ph;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ph <= 2'd0;
    else if (div_en && !stall) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
  end
  assign div_fin    = div_en && !stall && (ph == 2'd2);
  assign div_result = div_fin ? quot(div_a, div_b) : 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int g_cyc(input int i);
    if (i < gq.size()) return gq[i].cyc;
    return -1000;
  endfunction
  function automatic int g_id(input int i);
    if (i < gq.size()) return gq[i].id;
    return -1;
  endfunction
  function automatic logic [3:0] g_oh(input int i);
    if (i < gq.size()) return gq[i].oh;
    return 4'hF;
  endfunction
  function automatic int r_cyc(input int i);
    if (i < rq.size()) return rq[i].cyc;
    return -2000;
  endfunction
  function automatic int r_id(input int i);
    if (i < rq.size()) return rq[i].id;
    return -1;
  endfunction
  function automatic logic [15:0] r_data(input int i);
    if (i < rq.size()) return rq[i].data;
    return 16'hDEAD;
  endfunction
  function automatic logic r_dz(input int i);
    if (i < rq.size()) return rq[i].dz;
    return 1'bx;
  endfunction

  // Transaction-level model: an operation is outstanding, counts its RUN cycles, then owes a response
  bit          m_busy, m_rsp, m_wd, m_dz;
  int          m_run, m_ptr, m_id;
  logic [15:0] m_a, m_b, m_data;

  task automatic m_reset();
    m_busy = 0; m_rsp = 0; m_wd = 0; m_dz = 0;
    m_run = 0; m_ptr = 3; m_id = 0;
    m_a = 0; m_b = 0; m_data = 0;
  endtask

  always @(negedge clk) begin
    int k, win;
    bit open, exp_en;
    logic [3:0] exp_ready;
    cyc++;
    if (rst) m_reset();
    open = !m_busy || (m_rsp && rsp_ready && !m_wd);
    win = -1;
    for (int n = 1; n <= 4; n++) begin
      k = (m_ptr + n) % 4;
      if (win < 0 && req_valid[k]) win = k;
    end
    exp_ready = 4'b0;
    if (open && win >= 0) exp_ready[win] = 1'b1;
    exp_en = m_busy && !m_rsp && (m_b != 16'h0);

    chk("ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("busy", busy, m_busy);
    chk("div_en", div_en, exp_en);
    if (m_rsp) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_dz", rsp_dz, m_dz);
    end
    if (exp_en) begin
      chk("div_a", div_a, m_a);
      chk("div_b", div_b, m_b);
    end

    if (req_ready != 4'b0) begin
      int id;
      id = -1;
      for (int j = 0; j < 4; j++) if (req_ready[j]) id = j;
      gq.push_back('{cyc: cyc, id: id, oh: req_ready});
    end
    if (rsp_valid && rsp_ready) rq.push_back('{cyc: cyc, id: int'(rsp_id), data: rsp_data, dz: rsp_dz});
    if (div_en) en_cnt++;

    if (!rst) begin
      if (m_busy && !m_rsp) begin
        m_run++;
        if (m_b == 16'h0) m_rsp = 1;
        else if (!stall && m_run == 3) begin m_rsp = 1; m_data = quot(m_a, m_b); m_dz = 0; end
        else if (m_run == 4) begin m_rsp = 1; m_data = 16'h0; m_dz = 1; m_wd = 1; end
      end else if (m_rsp && rsp_ready) begin
        m_rsp = 0; m_busy = 0; m_wd = 0;
      end
      if (open && win >= 0) begin
        m_busy = 1; m_rsp = 0; m_run = 0; m_wd = 0;
        m_a = req_a[win*16 +: 16];
        m_b = req_b[win*16 +: 16];
        m_id = win; m_ptr = win;
        if (m_b == 16'h0) begin
          m_dz = 1;
          m_data = m_a[15] ? 16'h8000 : 16'h7FFF;
        end else m_dz = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k*16 +: 16] = a;
    req_b[k*16 +: 16] = b;
  endtask

  task automatic wait_grant(input int k);
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1;
    end
    chk("grant_seen", got, 1);
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("idle_seen", done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int ng, nr, e0;
    bit got;
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 0; stall = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_div_en", div_en, 0);
    chk("reset_rsp_data", rsp_data, 16'h0);
    tick();
    rst = 0;
    tick();

    // Single request from requester 0
    set_req(0, 16'h2000, 16'h4000); req_valid[0] = 1; rsp_ready = 1;
    ng = gq.size(); nr = rq.size(); e0 = en_cnt;
    wait_grant(0);
    wait_idle();
    chk("s1_onehot", g_oh(ng), 4'b0001);
    chk("s1_latency", r_cyc(nr) - g_cyc(ng), 4);
    chk("s1_id", r_id(nr), 0);
    chk("s1_data", r_data(nr), 16'h2000);
    chk("s1_dz", r_dz(nr), 0);
    chk("s1_en_cycles", en_cnt - e0, 3);

    // All four requesters valid continuously after a fresh reset
    rst = 1; tick(); tick(); rst = 0;
    set_req(0, 16'h1000, 16'h4000); set_req(1, 16'hE000, 16'h8000);
    set_req(2, 16'h4000, 16'h2000); set_req(3, 16'hC000, 16'h4000);
    ng = gq.size(); nr = rq.size();
    req_valid = 4'b1111;
    for (int i = 0; i < 40 && gq.size() < ng + 5; i++) tick();
    req_valid = 4'b0000;
    wait_idle();
    chk("rr_id0", g_id(ng), 0);
    chk("rr_id1", g_id(ng + 1), 1);
    chk("rr_id2", g_id(ng + 2), 2);
    chk("rr_id3", g_id(ng + 3), 3);
    chk("rr_id4", g_id(ng + 4), 0);
    for (int i = 1; i < 5; i++) chk("rr_spacing", g_cyc(ng + i) - g_cyc(ng + i - 1), 4);
    chk("rr_data2_sat", r_data(nr + 2), 16'h7FFF);
    chk("rr_data3", r_data(nr + 3), 16'hC000);

    // Divide by zero, negative then positive dividend
    set_req(2, 16'h9000, 16'h0000); req_valid[2] = 1;
    ng = gq.size(); nr = rq.size(); e0 = en_cnt;
    wait_grant(2);
    wait_idle();
    chk("dz1_latency", r_cyc(nr) - g_cyc(ng), 2);
    chk("dz1_id", r_id(nr), 2);
    chk("dz1_data", r_data(nr), 16'h8000);
    chk("dz1_dz", r_dz(nr), 1);
    set_req(2, 16'h1000, 16'h0000); req_valid[2] = 1;
    wait_grant(2);
    wait_idle();
    chk("dz2_latency", r_cyc(nr + 1) - g_cyc(ng + 1), 2);
    chk("dz2_data", r_data(nr + 1), 16'h7FFF);
    chk("dz2_dz", r_dz(nr + 1), 1);
    chk("dz_en_cycles", en_cnt - e0, 0);

    // Backpressure on the response side with a pending request
    rsp_ready = 0;
    set_req(1, 16'h3000, 16'h6000); req_valid[1] = 1;
    ng = gq.size(); nr = rq.size();
    wait_grant(1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    chk("bp_valid_seen", got, 1);
    tick();
    set_req(3, 16'h0800, 16'h4000); req_valid[3] = 1;
    repeat (10) tick();
    @(negedge clk);
    chk("bp_no_grant", gq.size() - ng, 1);
    chk("bp_valid_held", rsp_valid, 1);
    chk("bp_id_held", rsp_id, 1);
    chk("bp_data_held", rsp_data, 16'h2000);
    chk("bp_dz_held", rsp_dz, 0);
    tick();
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 0;
    wait_idle();
    chk("bp_rsp_count", rq.size() - nr, 2);
    chk("bp_rsp2_id", r_id(nr + 1), 3);
    chk("bp_rsp2_latency", r_cyc(nr + 1) - g_cyc(ng + 1), 4);
    chk("bp_rsp2_data", r_data(nr + 1), 16'h0800);

    // Divider that never finishes: watchdog response, forced idle cycle, then recovery
    stall = 1;
    set_req(0, 16'h2000, 16'h4000); set_req(1, 16'h1000, 16'h2000);
    req_valid[1:0] = 2'b11;
    ng = gq.size(); nr = rq.size(); e0 = en_cnt;
    wait_grant(0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rq.size() > nr) got = 1;
    end
    chk("wd_rsp_seen", got, 1);
    stall = 0;
    wait_grant(1);
    wait_idle();
    chk("wd_latency", r_cyc(nr) - g_cyc(ng), 5);
    chk("wd_data", r_data(nr), 16'h0);
    chk("wd_dz", r_dz(nr), 1);
    chk("wd_next_id", g_id(ng + 1), 1);
    chk("wd_idle_gap", g_cyc(ng + 1) - r_cyc(nr), 1);
    chk("wd_next_latency", r_cyc(nr + 1) - g_cyc(ng + 1), 4);
    chk("wd_next_data", r_data(nr + 1), 16'h2000);
    chk("wd_next_dz", r_dz(nr + 1), 0);
    chk("wd_en_cycles", en_cnt - e0, 7);

    // Reset during the second RUN cycle drops the operation
    set_req(2, 16'h1000, 16'h4000); req_valid[2] = 1;
    nr = rq.size();
    wait_grant(2);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rst_div_en", div_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 0;
    set_req(0, 16'h2000, 16'h4000); set_req(2, 16'h1000, 16'h4000);
    req_valid = 4'b0101;
    ng = gq.size();
    wait_grant(0);
    req_valid = 4'b0000;
    wait_idle();
    chk("post_rst_id", g_id(ng), 0);
    chk("post_rst_latency", r_cyc(nr) - g_cyc(ng), 4);
    chk("post_rst_data", r_data(nr), 16'h2000);
    chk("post_rst_rsp_count", rq.size() - nr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
